// File: rtl/flow_seq_pkg.sv
// Shared types and helpers for the optical-flow frame sequencer.
// Imported by the sequencer RTL and by its testbench.
package flow_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    STREAM,
    DRAIN,
    GAP,
    DONE
  } seq_state_t;

  function automatic int pixel_total(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/flow_frame_sequencer_if.sv
// Control/status bundle between host, frame source and the frame sequencer.
// The sequencer uses the slave modport; the host/frame-source side uses master.
interface flow_frame_sequencer_if #(
  parameter int PAIR_CNT_W = 8
);
  // All strobes are single-cycle pulses with no back-pressure: run/abort are
  // sampled on the clock edge they are high, num_pairs is sampled with an
  // accepted run, src_start/pair_done/seq_done/aborted are high for exactly one
  // cycle, and err_* stay high until the next accepted run.
  logic                  run;
  logic                  abort;
  logic [PAIR_CNT_W-1:0] num_pairs;
  logic                  src_start;
  logic                  src_pixel_valid;
  logic                  src_frame_done;
  logic                  busy;
  logic [PAIR_CNT_W-1:0] pair_idx;
  logic                  pair_done;
  logic                  seq_done;
  logic                  aborted;
  logic                  err_pixcnt;
  logic                  err_timeout;

  modport master (
    output run, abort, num_pairs, src_pixel_valid, src_frame_done,
    input  src_start, busy, pair_idx, pair_done, seq_done, aborted,
           err_pixcnt, err_timeout
  );

  modport slave (
    input  run, abort, num_pairs, src_pixel_valid, src_frame_done,
    output src_start, busy, pair_idx, pair_done, seq_done, aborted,
           err_pixcnt, err_timeout
  );

endinterface

// File: rtl/flow_seq_down_counter.sv
// Loadable down counter shared by the drain, gap and watchdog timers.
// zero_o flags that the current decrement takes the count from 1 to 0.
module flow_seq_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = dec_i && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/flow_frame_sequencer.sv
// Frame-pair scheduler: launch source, track frame, drain pipeline, blank, repeat.
// Define FLOW_SEQ_WATCHDOG_EN to add the STREAM watchdog (err_timeout/aborted exit).
module flow_frame_sequencer
  import flow_seq_pkg::*;
#(
  parameter int IMAGE_WIDTH    = 320,
  parameter int IMAGE_HEIGHT   = 240,
  parameter int PAIR_CNT_W     = 8,
  parameter int DRAIN_CYCLES   = 2 * IMAGE_WIDTH + 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2 * IMAGE_WIDTH * IMAGE_HEIGHT
) (
  input  logic       clk,
  input  logic       rst_n,
  flow_frame_sequencer_if.slave ctl,
  output seq_state_t state_o
);

`ifdef FLOW_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam int PIX_TOTAL = pixel_total(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int PIX_W     = $clog2(PIX_TOTAL) + 1;
  localparam int CNT_MAX0  = (DRAIN_CYCLES > GAP_CYCLES) ? DRAIN_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX   = (WD_EN && (TIMEOUT_CYCLES > CNT_MAX0)) ? TIMEOUT_CYCLES : CNT_MAX0;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  seq_state_t            state_q;
  logic [PAIR_CNT_W-1:0] num_pairs_q;
  logic [PAIR_CNT_W-1:0] pair_idx_q;
  logic [PIX_W-1:0]      pix_q;
  logic [PIX_W-1:0]      pix_d;
  logic                  busy_q;
  logic                  src_start_q;
  logic                  pair_done_q;
  logic                  seq_done_q;
  logic                  aborted_q;
  logic                  err_pixcnt_q;
  logic                  err_timeout_q;

  logic                  cnt_load;
  logic [CNT_W-1:0]      cnt_val;
  logic                  cnt_dec;
  logic                  cnt_zero;

  // Saturating pixel count including the current cycle's strobe.
  always_comb begin
    pix_d = pix_q;
    if (ctl.src_pixel_valid && (pix_q != '1)) begin
      pix_d = pix_q + 1'b1;
    end
  end

  // One timer serves all timed states; they never overlap.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    unique case (state_q)
`ifdef FLOW_SEQ_WATCHDOG_EN
      LAUNCH: begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(TIMEOUT_CYCLES);
      end
`endif
      STREAM: begin
        cnt_dec = 1'b1;
        if (ctl.src_frame_done) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        cnt_dec = 1'b1;
        if (cnt_zero && (GAP_CYCLES != 0)) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(GAP_CYCLES);
        end
      end
      GAP:     cnt_dec = 1'b1;
      default: ;
    endcase
  end

  flow_seq_down_counter #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      num_pairs_q   <= '0;
      pair_idx_q    <= '0;
      pix_q         <= '0;
      busy_q        <= 1'b0;
      src_start_q   <= 1'b0;
      pair_done_q   <= 1'b0;
      seq_done_q    <= 1'b0;
      aborted_q     <= 1'b0;
      err_pixcnt_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      src_start_q <= 1'b0;
      pair_done_q <= 1'b0;
      seq_done_q  <= 1'b0;
      aborted_q   <= 1'b0;
      // pair_idx is deliberately left alone on abort so it shows where we stopped.
      if (ctl.abort && (state_q != IDLE)) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        aborted_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (ctl.run && !ctl.abort) begin
              if (ctl.num_pairs != '0) begin
                num_pairs_q   <= ctl.num_pairs;
                pair_idx_q    <= '0;
                err_pixcnt_q  <= 1'b0;
                err_timeout_q <= 1'b0;
                busy_q        <= 1'b1;
                state_q       <= LAUNCH;
              end else begin
                seq_done_q <= 1'b1;
              end
            end
          end
          LAUNCH: begin
            src_start_q <= 1'b1;
            pix_q       <= '0;
            state_q     <= STREAM;
          end
          STREAM: begin
            pix_q <= pix_d;
            if (ctl.src_frame_done) begin
              if (pix_d != PIX_W'(PIX_TOTAL)) begin
                err_pixcnt_q <= 1'b1;
              end
              state_q <= DRAIN;
            end
`ifdef FLOW_SEQ_WATCHDOG_EN
            else if (cnt_zero) begin
              err_timeout_q <= 1'b1;
              aborted_q     <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= IDLE;
            end
`endif
          end
          DRAIN: begin
            if (cnt_zero) begin
              pair_done_q <= 1'b1;
              if (pair_idx_q == (num_pairs_q - 1'b1)) begin
                state_q <= DONE;
              end else begin
                pair_idx_q <= pair_idx_q + 1'b1;
                state_q    <= (GAP_CYCLES == 0) ? LAUNCH : GAP;
              end
            end
          end
          GAP: begin
            if (cnt_zero) begin
              state_q <= LAUNCH;
            end
          end
          DONE: begin
            seq_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ctl.src_start   = src_start_q;
  assign ctl.busy        = busy_q;
  assign ctl.pair_idx    = pair_idx_q;
  assign ctl.pair_done   = pair_done_q;
  assign ctl.seq_done    = seq_done_q;
  assign ctl.aborted     = aborted_q;
  assign ctl.err_pixcnt  = err_pixcnt_q;
  assign ctl.err_timeout = err_timeout_q & WD_EN;
  assign state_o         = state_q;

endmodule

// File: tb/tb_flow_frame_sequencer.sv
// Directed bench for flow_frame_sequencer: small 8x4 frames, table of sequences
// plus hand-written latency/abort/reset cases; watchdog case when FLOW_SEQ_WATCHDOG_EN.
module tb_flow_frame_sequencer;
  import flow_seq_pkg::*;

  localparam int W       = 8;
  localparam int H       = 4;
  localparam int PW      = 8;
  localparam int DRAIN_A = 5;
  localparam int GAP_A   = 3;
  localparam int TO_A    = 100;
  localparam int PIX     = pixel_total(W, H);

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  flow_frame_sequencer_if #(.PAIR_CNT_W(PW)) a_if ();
  flow_frame_sequencer_if #(.PAIR_CNT_W(PW)) b_if ();
  seq_state_t a_state;
  seq_state_t b_state;

  flow_frame_sequencer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PAIR_CNT_W(PW),
    .DRAIN_CYCLES(DRAIN_A), .GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TO_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ctl(a_if), .state_o(a_state)
  );

  flow_frame_sequencer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PAIR_CNT_W(PW),
    .DRAIN_CYCLES(1), .GAP_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ctl(b_if), .state_o(b_state)
  );

  // scoreboard counters
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // model frame source for dut_a
  logic src_pv = 1'b0;
  logic src_fd = 1'b0;
  logic inj_fd = 1'b0;
  int   src_len = PIX;
  bit   src_send_done = 1'b1;
  bit   src_busy = 1'b0;
  int   src_left = 0;
  int   t_fd = -1000;
  assign a_if.src_pixel_valid = src_pv;
  assign a_if.src_frame_done  = src_fd | inj_fd;

  initial begin
    forever begin
      @(negedge clk);
      src_pv = 1'b0;
      src_fd = 1'b0;
      if (!rst_n) begin
        src_busy = 1'b0;
      end else begin
        if (src_busy) begin
          src_pv = 1'b1;
          src_left--;
          if (src_left == 0) begin
            src_fd   = src_send_done;
            src_busy = 1'b0;
            if (src_send_done) t_fd = cyc;
          end
        end
        if (a_if.src_start) begin
          src_busy = 1'b1;
          src_left = src_len;
        end
      end
    end
  end

  // output monitor for dut_a
  int n_start, n_pdone, n_sdone, n_abort, n_busy;
  int t_run, t_start, t_first_start, t_pdone, t_sdone, t_abort, t_gap;

  task automatic clr_counts();
    n_start = 0; n_pdone = 0; n_sdone = 0; n_abort = 0; n_busy = 0;
    t_start = -1000; t_first_start = -1000; t_pdone = -1000;
    t_sdone = -1000; t_abort = -1000; t_gap = -1000;
  endtask

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (a_if.src_start) begin
        check("start_pair_idx", a_if.pair_idx, n_start);
        if (n_start == 0) t_first_start = cyc;
        if (n_pdone > 0) t_gap = cyc - t_pdone;
        n_start++;
        t_start = cyc;
      end
      if (a_if.pair_done) begin n_pdone++; t_pdone = cyc; end
      if (a_if.seq_done)  begin n_sdone++; t_sdone = cyc; end
      if (a_if.aborted)   begin n_abort++; t_abort = cyc; end
      if (a_if.busy)      n_busy++;
    end
  end

  // driver tasks
  task automatic drive_run(input int np);
    @(negedge clk);
    a_if.run       = 1'b1;
    a_if.num_pairs = PW'(np);
    t_run          = cyc;
    @(negedge clk);
    a_if.run = 1'b0;
  endtask

  task automatic wait_for_end(input int budget, input string nm);
    int s0 = n_sdone;
    int a0 = n_abort;
    int i  = 0;
    while (i < budget && n_sdone == s0 && n_abort == a0) begin
      @(negedge clk);
      i++;
    end
    check(nm, i < budget, 1);
  endtask

  task automatic wait_state(input seq_state_t st, input int idx, input int budget, input string nm);
    int i = 0;
    while (i < budget && !(a_state == st && a_if.pair_idx == PW'(idx))) begin
      @(negedge clk);
      i++;
    end
    check(nm, i < budget, 1);
  endtask

  task automatic b_frame();
    for (int k = 0; k < PIX; k++) begin
      b_if.src_pixel_valid = 1'b1;
      b_if.src_frame_done  = (k == PIX - 1);
      @(negedge clk);
    end
    b_if.src_pixel_valid = 1'b0;
    b_if.src_frame_done  = 1'b0;
  endtask

  typedef struct {
    int np;
    int len;
    int exp_starts;
    int exp_pdone;
    int exp_sdone;
    int exp_err;
    int exp_idx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

  initial begin
    int prev_err;
    int t_fd_b, t_pd_b, t_st_b, t_sd_b, ok;

    vecs[0] = '{np: 3, len: PIX,     exp_starts: 3, exp_pdone: 3, exp_sdone: 1, exp_err: 0, exp_idx: 2};
    vecs[1] = '{np: 2, len: PIX - 1, exp_starts: 2, exp_pdone: 2, exp_sdone: 1, exp_err: 1, exp_idx: 1};
    vecs[2] = '{np: 1, len: PIX,     exp_starts: 1, exp_pdone: 1, exp_sdone: 1, exp_err: 0, exp_idx: 0};
    vecs[3] = '{np: 2, len: PIX + 1, exp_starts: 2, exp_pdone: 2, exp_sdone: 1, exp_err: 1, exp_idx: 1};
    vecs[4] = '{np: 4, len: PIX,     exp_starts: 4, exp_pdone: 4, exp_sdone: 1, exp_err: 0, exp_idx: 3};

    a_if.run = 1'b0; a_if.abort = 1'b0; a_if.num_pairs = '0;
    b_if.run = 1'b0; b_if.abort = 1'b0; b_if.num_pairs = '0;
    b_if.src_pixel_valid = 1'b0; b_if.src_frame_done = 1'b0;
    clr_counts();
    t_run = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_state",       a_state, IDLE);
    check("rst_busy",        a_if.busy, 0);
    check("rst_src_start",   a_if.src_start, 0);
    check("rst_pair_idx",    a_if.pair_idx, 0);
    check("rst_pair_done",   a_if.pair_done, 0);
    check("rst_seq_done",    a_if.seq_done, 0);
    check("rst_aborted",     a_if.aborted, 0);
    check("rst_err_pixcnt",  a_if.err_pixcnt, 0);
    check("rst_err_timeout", a_if.err_timeout, 0);

    // latencies on a two-pair run
    clr_counts();
    src_len = PIX;
    drive_run(2);
    wait_for_end(1000, "lat_end");
    check("lat_run_to_start",   t_first_start - t_run, 2);
    check("lat_pdone_to_start", t_gap, GAP_A + 1);
    check("lat_fd_to_pdone",    t_pdone - t_fd, DRAIN_A + 1);
    check("lat_pdone_to_sdone", t_sdone - t_pdone, 1);
    check("lat_busy_after",     a_if.busy, 0);

    // table of sequences
    prev_err = 0;
    for (int v = 0; v < 5; v++) begin
      check("tbl_err_held", a_if.err_pixcnt, prev_err);
      clr_counts();
      src_len = vecs[v].len;
      drive_run(vecs[v].np);
      wait_for_end(2000, "tbl_end");
      repeat (3) @(negedge clk);
      check("tbl_starts",      n_start, vecs[v].exp_starts);
      check("tbl_pair_done",   n_pdone, vecs[v].exp_pdone);
      check("tbl_seq_done",    n_sdone, vecs[v].exp_sdone);
      check("tbl_aborted",     n_abort, 0);
      check("tbl_err_pixcnt",  a_if.err_pixcnt, vecs[v].exp_err);
      check("tbl_err_timeout", a_if.err_timeout, 0);
      check("tbl_pair_idx",    a_if.pair_idx, vecs[v].exp_idx);
      check("tbl_busy",        a_if.busy, 0);
      prev_err = vecs[v].exp_err;
    end
    src_len = PIX;

    // num_pairs == 0
    clr_counts();
    drive_run(0);
    repeat (4) @(negedge clk);
    check("zero_sdone_lat", t_sdone - t_run, 1);
    check("zero_sdone_cnt", n_sdone, 1);
    check("zero_no_start",  n_start, 0);
    check("zero_no_busy",   n_busy, 0);
    check("zero_pair_idx",  a_if.pair_idx, 3);

    // run while busy is ignored
    clr_counts();
    drive_run(1);
    wait_state(STREAM, 0, 20, "busy_wait_stream");
    drive_run(3);
    wait_for_end(1000, "busy_end");
    repeat (3) @(negedge clk);
    check("busy_run_starts", n_start, 1);
    check("busy_run_sdone",  n_sdone, 1);

    // abort in DRAIN of pair 1
    clr_counts();
    drive_run(3);
    wait_state(DRAIN, 1, 500, "abort_wait_drain");
    a_if.abort = 1'b1;
    t_fd_b = cyc;
    @(negedge clk);
    a_if.abort = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_lat",       t_abort - t_fd_b, 1);
    check("abort_cnt",       n_abort, 1);
    check("abort_no_sdone",  n_sdone, 0);
    check("abort_state",     a_state, IDLE);
    check("abort_busy",      a_if.busy, 0);
    check("abort_pair_idx",  a_if.pair_idx, 1);
    check("abort_pdone",     n_pdone, 1);
    check("abort_starts",    n_start, 2);

    // stray frame_done in IDLE
    @(negedge clk);
    inj_fd = 1'b1;
    @(negedge clk);
    inj_fd = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_fd_state", a_state, IDLE);
    check("stray_fd_err",   a_if.err_pixcnt, 0);

    // abort + run together in IDLE
    clr_counts();
    @(negedge clk);
    a_if.run = 1'b1; a_if.abort = 1'b1; a_if.num_pairs = PW'(2);
    @(negedge clk);
    a_if.run = 1'b0; a_if.abort = 1'b0;
    repeat (4) @(negedge clk);
    check("abrun_no_abort", n_abort, 0);
    check("abrun_no_start", n_start, 0);
    check("abrun_no_busy",  n_busy, 0);

    // dut_b: DRAIN=1, GAP=0 relaunch timing
    t_fd_b = -1000; t_pd_b = -1000; t_st_b = -1000; t_sd_b = -1000;
    @(negedge clk);
    b_if.run = 1'b1; b_if.num_pairs = PW'(2);
    @(negedge clk);
    b_if.run = 1'b0;
    ok = 0;
    for (int i = 0; i < 10 && ok == 0; i++) begin
      @(negedge clk);
      if (b_if.src_start) ok = 1;
    end
    check("b_first_start", ok, 1);
    for (int k = 0; k < PIX; k++) begin
      b_if.src_pixel_valid = 1'b1;
      b_if.src_frame_done  = (k == PIX - 1);
      if (k == PIX - 1) t_fd_b = cyc;
      @(negedge clk);
    end
    b_if.src_pixel_valid = 1'b0;
    b_if.src_frame_done  = 1'b0;
    for (int i = 0; i < 20 && t_st_b < 0; i++) begin
      @(negedge clk);
      if (b_if.pair_done) t_pd_b = cyc;
      if (b_if.src_start) t_st_b = cyc;
    end
    check("b_fd_to_pdone", t_pd_b - t_fd_b, 2);
    check("b_fd_to_start", t_st_b - t_fd_b, 3);
    check("b_pair_idx1",   b_if.pair_idx, 1);
    b_frame();
    t_fd_b = cyc - 1;
    for (int i = 0; i < 20 && t_sd_b < 0; i++) begin
      @(negedge clk);
      if (b_if.pair_done) t_pd_b = cyc;
      if (b_if.seq_done)  t_sd_b = cyc;
    end
    check("b_last_pdone", t_pd_b - t_fd_b, 2);
    check("b_seq_done",   t_sd_b - t_fd_b, 3);
    check("b_idle",       b_state, IDLE);
    check("b_err_pixcnt", b_if.err_pixcnt, 0);

`ifdef FLOW_SEQ_WATCHDOG_EN
    // watchdog: source never signals frame_done
    clr_counts();
    src_send_done = 1'b0;
    drive_run(1);
    wait_for_end(400, "wd_end");
    repeat (2) @(negedge clk);
    check("wd_err_timeout", a_if.err_timeout, 1);
    check("wd_lat",         t_abort - t_start, TO_A);
    check("wd_no_sdone",    n_sdone, 0);
    check("wd_no_pdone",    n_pdone, 0);
    check("wd_busy",        a_if.busy, 0);
    src_send_done = 1'b1;
    clr_counts();
    drive_run(1);
    wait_for_end(400, "wd_clean_end");
    check("wd_err_cleared", a_if.err_timeout, 0);
    check("wd_clean_sdone", n_sdone, 1);
`endif

    // reset in the middle of a sequence
    clr_counts();
    drive_run(2);
    wait_state(GAP, 1, 500, "rst_wait_gap");
    rst_n = 1'b0;
    #1;
    check("mid_rst_state",    a_state, IDLE);
    check("mid_rst_busy",     a_if.busy, 0);
    check("mid_rst_pair_idx", a_if.pair_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_counts();
    repeat (8) @(negedge clk);
    check("mid_rst_no_start", n_start, 0);
    check("mid_rst_idle",     a_state, IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
